// File: rtl/text_pkg.sv
// Shared constants for the text line renderer: font geometry, character codes
// and pipeline depth.
package text_pkg;

  localparam int DEF_GLYPH_W = 5;
  localparam int DEF_GLYPH_H = 7;
  localparam int CODE_W      = 6;
  localparam int ROW_W       = 3;
  localparam int LATENCY     = 3;

  localparam logic [CODE_W-1:0] CHAR_BLANK = 6'd0;
  localparam logic [CODE_W-1:0] CHAR_A     = 6'd1;
  localparam logic [CODE_W-1:0] CHAR_Z     = 6'd26;
  localparam logic [CODE_W-1:0] CHAR_0     = 6'd27;
  localparam logic [CODE_W-1:0] CHAR_9     = 6'd36;
  localparam logic [CODE_W-1:0] CHAR_DASH  = 6'd37;
  localparam logic [CODE_W-1:0] CHAR_COLON = 6'd38;

endpackage

// File: rtl/font_rom.sv
// 5x7 font ROM with one registered read port; returns one glyph row, MSB is the
// leftmost column. Unassigned codes and rows past the glyph height read blank.
module font_rom
  import text_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CODE_W-1:0]      code,
  input  logic [ROW_W-1:0]       row,
  output logic [DEF_GLYPH_W-1:0] bits
);

  logic [DEF_GLYPH_W*DEF_GLYPH_H-1:0] glyph;

  // Each entry lists rows top to bottom, five columns per row.
  always_comb begin
    glyph = '0;
    case (code)
      6'd1:  glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
      6'd2:  glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
      6'd3:  glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
      6'd4:  glyph = 35'b11100_10010_10001_10001_10001_10010_11100;
      6'd5:  glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
      6'd6:  glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
      6'd7:  glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
      6'd8:  glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
      6'd9:  glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
      6'd10: glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
      6'd11: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
      6'd12: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
      6'd13: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
      6'd14: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
      6'd15: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
      6'd16: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
      6'd17: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
      6'd18: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
      6'd19: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
      6'd20: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
      6'd21: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
      6'd22: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
      6'd23: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
      6'd24: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
      6'd25: glyph = 35'b10001_10001_10001_01010_00100_00100_00100;
      6'd26: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
      6'd27: glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
      6'd28: glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
      6'd29: glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
      6'd30: glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
      6'd31: glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
      6'd32: glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
      6'd33: glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
      6'd34: glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
      6'd35: glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
      6'd36: glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
      6'd37: glyph = 35'b00000_00000_00000_11111_00000_00000_00000;
      6'd38: glyph = 35'b00000_01100_01100_00000_01100_01100_00000;
      default: glyph = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (int'(row) < DEF_GLYPH_H) begin
      bits <= DEF_GLYPH_W'(glyph >> (DEF_GLYPH_W * (DEF_GLYPH_H - 1 - int'(row))));
    end else begin
      bits <= '0;
    end
  end

endmodule

// File: rtl/text_line_render.sv
// Three-stage text line renderer: scan position -> glyph cell lookup -> font row
// -> lit pixel, with a writable character buffer and a frame-counted blink.
module text_line_render
  import text_pkg::*;
#(
  parameter int NUM_CHARS    = 8,
  parameter int GLYPH_W      = DEF_GLYPH_W,
  parameter int GLYPH_H      = DEF_GLYPH_H,
  parameter int SPACING      = 1,
  parameter int SCALE        = 4,
  parameter int BLINK_FRAMES = 30,
  localparam int IDX_W       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              frame_start,
  input  logic [9:0]        start_x,
  input  logic [9:0]        start_y,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              blink_en,
  output logic              display
);

  localparam int CELL  = (GLYPH_W + SPACING) * SCALE;
  localparam int BOX_W = NUM_CHARS * CELL;
  localparam int BOX_H = GLYPH_H * SCALE;
  localparam int SH    = $clog2(SCALE);
  localparam int COL_W = (GLYPH_W + SPACING > 1) ? $clog2(GLYPH_W + SPACING) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [GLYPH_W-1:0] LEFT_COL = GLYPH_W'(1) << (GLYPH_W - 1);

  logic [CODE_W-1:0] char_buf [NUM_CHARS];

  logic [10:0]       x_ext, y_ext, sx_ext, sy_ext, rx, ry;
  logic              in_box;
  logic [IDX_W-1:0]  rd_idx;

  logic              s1_in_box, s2_in_box;
  logic [COL_W-1:0]  s1_col, s2_col;
  logic [ROW_W-1:0]  s1_row;
  logic [CODE_W-1:0] s1_code;
  logic [GLYPH_W-1:0] rom_bits;

  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_phase;

  // Widened to 11 bits so a box reaching past column 1023 still compares correctly.
  always_comb begin
    x_ext  = {1'b0, x};
    y_ext  = {1'b0, y};
    sx_ext = {1'b0, start_x};
    sy_ext = {1'b0, start_y};
    rx     = x_ext - sx_ext;
    ry     = y_ext - sy_ext;
    in_box = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(BOX_W)) &&
             (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(BOX_H));
    rd_idx = IDX_W'(rx / 11'(CELL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) char_buf[i] <= '0;
    end else if (wr_en && (int'(wr_idx) < NUM_CHARS)) begin
      char_buf[wr_idx] <= wr_code;
    end
  end

  // Stage 1 reads char_buf before this edge's write lands, so a same-cycle
  // write to the slot being scanned shows up one pixel later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in_box <= 1'b0;
      s1_code   <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s2_in_box <= 1'b0;
      s2_col    <= '0;
      display   <= 1'b0;
    end else begin
      s1_in_box <= in_box;
      s1_code   <= in_box ? char_buf[rd_idx] : CHAR_BLANK;
      s1_col    <= COL_W'((rx % 11'(CELL)) >> SH);
      s1_row    <= ROW_W'(ry >> SH);
      s2_in_box <= s1_in_box;
      s2_col    <= s1_col;
      // Spacing columns shift the mask off the end and read as unlit.
      display   <= s2_in_box && (|(rom_bits & (LEFT_COL >> s2_col))) &&
                   !(blink_en && blink_phase);
    end
  end

  font_rom u_font_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .code  (s1_code),
    .row   (s1_row),
    .bits  (rom_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_line_render.sv
// Bench for text_line_render: directed boundary cases plus random scans, all
// compared against a pixel-level model evaluated three clocks ahead.
module tb_text_line_render;

  localparam int NC   = 8;
  localparam int GW   = 5;
  localparam int GH   = 7;
  localparam int SC   = 4;
  localparam int CELL = (GW + 1) * SC;
  localparam int BF   = 30;

  // Row-major, top row first, leftmost column is the MSB of each row.
  localparam logic [34:0] FONT [39] = '{
    35'b0,
    35'b01110_10001_10001_11111_10001_10001_10001,
    35'b11110_10001_10001_11110_10001_10001_11110,
    35'b01110_10001_10000_10000_10000_10001_01110,
    35'b11100_10010_10001_10001_10001_10010_11100,
    35'b11111_10000_10000_11110_10000_10000_11111,
    35'b11111_10000_10000_11110_10000_10000_10000,
    35'b01110_10001_10000_10111_10001_10001_01111,
    35'b10001_10001_10001_11111_10001_10001_10001,
    35'b01110_00100_00100_00100_00100_00100_01110,
    35'b00111_00010_00010_00010_00010_10010_01100,
    35'b10001_10010_10100_11000_10100_10010_10001,
    35'b10000_10000_10000_10000_10000_10000_11111,
    35'b10001_11011_10101_10101_10001_10001_10001,
    35'b10001_10001_11001_10101_10011_10001_10001,
    35'b01110_10001_10001_10001_10001_10001_01110,
    35'b11110_10001_10001_11110_10000_10000_10000,
    35'b01110_10001_10001_10001_10101_10010_01101,
    35'b11110_10001_10001_11110_10100_10010_10001,
    35'b01111_10000_10000_01110_00001_00001_11110,
    35'b11111_00100_00100_00100_00100_00100_00100,
    35'b10001_10001_10001_10001_10001_10001_01110,
    35'b10001_10001_10001_10001_10001_01010_00100,
    35'b10001_10001_10001_10101_10101_10101_01010,
    35'b10001_10001_01010_00100_01010_10001_10001,
    35'b10001_10001_10001_01010_00100_00100_00100,
    35'b11111_00001_00010_00100_01000_10000_11111,
    35'b01110_10001_10011_10101_11001_10001_01110,
    35'b00100_01100_00100_00100_00100_00100_01110,
    35'b01110_10001_00001_00010_00100_01000_11111,
    35'b11111_00010_00100_00010_00001_10001_01110,
    35'b00010_00110_01010_10010_11111_00010_00010,
    35'b11111_10000_11110_00001_00001_10001_01110,
    35'b00110_01000_10000_11110_10001_10001_01110,
    35'b11111_00001_00010_00100_01000_01000_01000,
    35'b01110_10001_10001_01110_10001_10001_01110,
    35'b01110_10001_10001_01111_00001_00010_01100,
    35'b00000_00000_00000_11111_00000_00000_00000,
    35'b00000_01100_01100_00000_01100_01100_00000
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0, y = '0, start_x = 10'd100, start_y = 10'd50;
  logic       frame_start = 1'b0, wr_en = 1'b0, blink_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [5:0] wr_code = '0;
  logic       display;

  int    n_chk = 0, n_fail = 0;
  int    mbuf [NC];
  int    frames = 0;
  bit    pv [3];
  bit    pe [3];
  string ptag [3];

  always #5 clk = ~clk;

  text_line_render dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .start_x     (start_x),
    .start_y     (start_y),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_code     (wr_code),
    .blink_en    (blink_en),
    .display     (display)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic bit model_pix(int px, int py);
    int sx, sy, rx, ry, col, row, code;
    sx = int'(start_x);
    sy = int'(start_y);
    if (px < sx || px >= sx + NC * CELL || py < sy || py >= sy + GH * SC) return 1'b0;
    rx   = px - sx;
    ry   = py - sy;
    col  = (rx % CELL) / SC;
    row  = ry / SC;
    code = mbuf[rx / CELL];
    if (col >= GW || code < 1 || code > 38) return 1'b0;
    if (blink_en && ((frames / BF) % 2 == 1)) return 1'b0;
    return FONT[code][34 - (row * GW + col)];
  endfunction

  // One pixel clock: retire the oldest expectation, then present new inputs.
  task automatic step(input int px, input int py, input bit chk_en, input bit we,
                      input int widx, input int wcode, input bit fs);
    @(negedge clk);
    if (pv[2]) check_bit(ptag[2], display, pe[2]);
    pv[2] = pv[1]; pe[2] = pe[1]; ptag[2] = ptag[1];
    pv[1] = pv[0]; pe[1] = pe[0]; ptag[1] = ptag[0];
    if (fs) frames++;
    pv[0]   = chk_en;
    pe[0]   = model_pix(px, py);
    ptag[0] = $sformatf("pix(%0d,%0d)", px, py);
    if (we && widx < NC) mbuf[widx] = wcode;
    x = px[9:0]; y = py[9:0];
    wr_en = we; wr_idx = widx[2:0]; wr_code = wcode[5:0];
    frame_start = fs;
  endtask

  task automatic pix(input int px, input int py);
    step(px, py, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int idx, input int code);
    step(0, 0, 1'b0, 1'b1, idx, code, 1'b0);
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_start = 1'b1;
    wr_en = 1'b0;
    #1 check_bit("reset_async", display, 1'b0);
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    for (int i = 0; i < NC; i++) mbuf[i] = 0;
    frames = 0;
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int sx, sy;
    for (int i = 0; i < NC; i++) mbuf[i] = 0;
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;

    // Reset state, with a frame pulse that must not reach the blink counter.
    repeat (2) @(negedge clk);
    check_bit("reset_state", display, 1'b0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    rst_n = 1'b1;

    // 'A' in slot 0, scan across its top row and down its left columns.
    wr(0, 1);
    for (int px = 98; px <= 118; px++) pix(px, 50);
    for (int py = 48; py <= 58; py++) pix(104, py);

    // Spacing columns and box edges with every slot holding 'H'.
    for (int i = 0; i < NC; i++) wr(i, 8);
    for (int px = 120; px <= 123; px++) pix(px, 50);
    pix(99, 50);  pix(100, 50); pix(291, 50); pix(292, 50);
    pix(268, 50); pix(268, 77); pix(268, 78); pix(100, 49);

    // Same-cycle write and scan of one slot sees the old glyph.
    wr(0, 1);
    step(104, 50, 1'b1, 1'b1, 0, 0, 1'b0);
    pix(104, 50);
    step(172, 50, 1'b1, 1'b1, 3, 37, 1'b0);
    pix(172, 50);
    pix(180, 62);

    // Reset while a lit pixel is being output; buffer must read blank afterwards.
    wr(0, 8);
    repeat (4) pix(100, 50);
    do_reset();
    pix(100, 50);
    pix(268, 77);
    pix(200, 60);

    // Random frames: random box position, codes, blink enable and mid-scan writes.
    for (int f = 0; f < 2; f++) begin
      flush();
      start_x  = 10'($urandom_range(0, 900));
      start_y  = 10'($urandom_range(0, 470));
      blink_en = 1'($urandom_range(0, 1));
      step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < NC; i++) wr(i, $urandom_range(0, 40));
      sx = int'(start_x);
      sy = int'(start_y);
      for (int py = sy - 2; py <= sy + GH * SC + 1; py++) begin
        for (int px = sx - 3; px <= sx + NC * CELL + 2; px++) begin
          if (px >= 0 && px <= 1023 && py >= 0 && py <= 1023)
            step(px, py, 1'b1, ($urandom_range(0, 31) == 0), $urandom_range(0, 7),
                 $urandom_range(0, 63), 1'b0);
        end
      end
      repeat (600)
        step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1,
             ($urandom_range(0, 15) == 0), $urandom_range(0, 7), $urandom_range(0, 63), 1'b0);
    end

    // Blink: dark after 30 frame pulses, lit again after 60.
    flush();
    do_reset();
    start_x = 10'd100;
    start_y = 10'd50;
    blink_en = 1'b1;
    wr(0, 1);
    for (int k = 1; k <= 65; k++) begin
      flush();
      step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
      pix(104, 50);
      pix(115, 50);
      pix(100, 54);
      pix(120, 50);
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
